// File: rtl/adpll_pkg.sv
// Shared ADPLL types and helpers: gear states, DCO code midpoint/max and a
// wide signed saturate used for both the integrator and output clamps.
package adpll_pkg;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    LOCKED  = 2'd2
  } gear_state_t;

  function automatic int mid_code(input int w);
    return 1 << (w - 1);
  endfunction

  function automatic int cmax_code(input int w);
    return (1 << w) - 1;
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                  input logic signed [63:0] lo,
                                                  input logic signed [63:0] hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

endpackage

// File: rtl/pi_loop_filter_gs_lock_detector.sv
// Lock detector: error magnitude compare, in-lock run counter and the
// ACQUIRE/TRACK/LOCKED gear state machine.
module lock_detector
  import adpll_pkg::*;
#(
  parameter int ERROR_WIDTH = 8,
  parameter int LOCK_THRESH = 2,
  parameter int LOCK_COUNT  = 16,
  parameter int UNLOCK_MULT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [ERROR_WIDTH-1:0] error,
  input  logic                          valid,
  input  logic                          freeze,
  output gear_state_t                   gear_state,
  output logic                          locked
);

  localparam int MAG_W = ERROR_WIDTH + 1;
  localparam int CNT_W = $clog2(LOCK_COUNT + 1);
  localparam logic [MAG_W-1:0] THRESH  = MAG_W'(LOCK_THRESH);
  localparam logic [MAG_W-1:0] UNLOCK  = MAG_W'(UNLOCK_MULT * LOCK_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_COUNT);

  logic signed [MAG_W-1:0] err_x;
  logic        [MAG_W-1:0] mag;
  logic                    in_lock;
  logic                    far_out;
  logic        [CNT_W-1:0] cnt;
  logic        [CNT_W-1:0] cnt_inc;

  // One extra bit so the most negative error yields its true magnitude
  assign err_x   = {error[ERROR_WIDTH-1], error};
  assign mag     = err_x[MAG_W-1] ? MAG_W'(-err_x) : MAG_W'(err_x);
  assign in_lock = (mag <= THRESH);
  assign far_out = (mag > UNLOCK);
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      gear_state <= ACQUIRE;
      cnt        <= '0;
      locked     <= 1'b0;
    end else if (valid && !freeze) begin
      if (in_lock) begin
        if (gear_state == ACQUIRE && cnt_inc == CNT_MAX) begin
          gear_state <= TRACK;
          cnt        <= '0;
          locked     <= 1'b0;
        end else if (gear_state == TRACK && cnt_inc == CNT_MAX) begin
          gear_state <= LOCKED;
          cnt        <= '0;
          locked     <= 1'b1;
        end else begin
          cnt <= cnt_inc;
        end
      end else begin
        cnt <= '0;
        if (gear_state == TRACK && far_out) begin
          gear_state <= ACQUIRE;
          locked     <= 1'b0;
        end else if (gear_state == LOCKED) begin
          gear_state <= TRACK;
          locked     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/pi_loop_filter_gs.sv
// Gear-shifted PI loop filter: two-stage pipeline from PFD error to DCO code,
// with anti-windup integrator clamp, output saturation and freeze.
module pi_loop_filter_gs
  import adpll_pkg::*;
#(
  parameter int ERROR_WIDTH   = 8,
  parameter int DCO_CC_WIDTH  = 5,
  parameter int KP_WIDTH      = 5,
  parameter int KP_FRAC_WIDTH = 4,
  parameter int KI_WIDTH      = 11,
  parameter int KI_FRAC_WIDTH = 10,
  parameter int ACC_WIDTH     = 24,
  parameter int GEAR_SHIFT    = 2,
  parameter int LOCK_THRESH   = 2,
  parameter int LOCK_COUNT    = 16,
  parameter int UNLOCK_MULT   = 4
) (
  input  logic                          gen_clk_i,
  input  logic                          reset_i,
  input  logic signed [ERROR_WIDTH-1:0] error_i,
  input  logic                          error_valid_i,
  input  logic        [KP_WIDTH-1:0]    kp_i,
  input  logic        [KI_WIDTH-1:0]    ki_i,
  input  logic                          freeze_i,
  output logic        [DCO_CC_WIDTH-1:0] dco_cc_o,
  output logic                          dco_cc_valid_o,
  output logic                          locked_o,
  output logic        [1:0]             gear_state_o
);

  localparam int KP_E_W = KP_WIDTH + GEAR_SHIFT;
  localparam int KI_E_W = KI_WIDTH + GEAR_SHIFT;
  localparam int PP_W   = ERROR_WIDTH + KP_E_W + 1;
  localparam int PI_W   = ERROR_WIDTH + KI_E_W + 1;
  localparam int MID    = mid_code(DCO_CC_WIDTH);
  localparam int CMAX   = cmax_code(DCO_CC_WIDTH);
  localparam longint ACC_LO = -(longint'(MID) <<< KI_FRAC_WIDTH);
  localparam longint ACC_HI = longint'(CMAX - MID) <<< KI_FRAC_WIDTH;

  gear_state_t gear;
  logic        locked;

  lock_detector #(
    .ERROR_WIDTH (ERROR_WIDTH),
    .LOCK_THRESH (LOCK_THRESH),
    .LOCK_COUNT  (LOCK_COUNT),
    .UNLOCK_MULT (UNLOCK_MULT)
  ) u_lock_detector (
    .clk        (gen_clk_i),
    .rst        (reset_i),
    .error      (error_i),
    .valid      (error_valid_i),
    .freeze     (freeze_i),
    .gear_state (gear),
    .locked     (locked)
  );

  assign gear_state_o = gear;
  assign locked_o     = locked;

  logic        [KP_E_W-1:0] kp_eff;
  logic        [KI_E_W-1:0] ki_eff;
  logic signed [PP_W-1:0]   kp_s;
  logic signed [PI_W-1:0]   ki_s;
  logic signed [PP_W-1:0]   prod_p;
  logic signed [PI_W-1:0]   prod_i;

  assign kp_eff = (gear == ACQUIRE) ? KP_E_W'(kp_i) << GEAR_SHIFT : KP_E_W'(kp_i);
  assign ki_eff = (gear == ACQUIRE) ? KI_E_W'(ki_i) << GEAR_SHIFT : KI_E_W'(ki_i);
  assign kp_s   = PP_W'($signed({1'b0, kp_eff}));
  assign ki_s   = PI_W'($signed({1'b0, ki_eff}));
  assign prod_p = PP_W'(error_i) * kp_s;
  assign prod_i = PI_W'(error_i) * ki_s;

  // Stage 1: full-precision products registered on the sample edge
  logic signed [PP_W-1:0] prod_p_p1;
  logic signed [PI_W-1:0] prod_i_p1;
  logic                   frz_p1;
  logic                   vld_p1;

  always_ff @(posedge gen_clk_i) begin
    if (error_valid_i) begin
      prod_p_p1 <= prod_p;
      prod_i_p1 <= prod_i;
      frz_p1    <= freeze_i;
    end
  end

  // Stage 2: integrate with anti-windup, combine and saturate to the code range
  logic signed [ACC_WIDTH-1:0]    acc;
  logic signed [ACC_WIDTH-1:0]    acc_next;
  logic signed [63:0]             acc_sum;
  logic signed [63:0]             cc_sum;
  logic        [DCO_CC_WIDTH-1:0] cc_next;

  always_comb begin
    acc_sum  = longint'(acc) + longint'(prod_i_p1);
    acc_next = frz_p1 ? acc : ACC_WIDTH'(saturate(acc_sum, ACC_LO, ACC_HI));
    cc_sum   = longint'(MID) + (longint'(prod_p_p1) >>> KP_FRAC_WIDTH)
             + (longint'(acc_next) >>> KI_FRAC_WIDTH);
    cc_next  = DCO_CC_WIDTH'(saturate(cc_sum, 64'sd0, longint'(CMAX)));
  end

  always_ff @(posedge gen_clk_i) begin
    if (reset_i) begin
      vld_p1         <= 1'b0;
      dco_cc_valid_o <= 1'b0;
      dco_cc_o       <= DCO_CC_WIDTH'(MID);
      acc            <= '0;
    end else begin
      vld_p1         <= error_valid_i;
      dco_cc_valid_o <= vld_p1;
      if (vld_p1) begin
        acc      <= acc_next;
        dco_cc_o <= cc_next;
      end
    end
  end

endmodule

// File: tb/tb_pi_loop_filter_gs.sv
// Bench for pi_loop_filter_gs: table of stimulus segments with expected end
// state, plus a queue of per-sample predictions from an integer reference model.
module tb_pi_loop_filter_gs;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic signed [7:0] err = '0;
  logic              ev  = 1'b0;
  logic        [4:0] kp  = '0;
  logic       [10:0] ki  = '0;
  logic              frz = 1'b0;
  logic        [4:0] dco;
  logic              dv;
  logic              lk;
  logic        [1:0] gs;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int strobes = 0;

  typedef struct {
    int due;
    int val;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    bit rst;
    int e;
    int kp;
    int ki;
    bit frz;
    int reps;
    int exp_dco;
    int exp_gear;
  } vec_t;
  vec_t tbl[$];

  int m_acc = 0;
  int m_gear = 0;
  int m_cnt = 0;

  pi_loop_filter_gs dut (
    .gen_clk_i      (clk),
    .reset_i        (rst),
    .error_i        (err),
    .error_valid_i  (ev),
    .kp_i           (kp),
    .ki_i           (ki),
    .freeze_i       (frz),
    .dco_cc_o       (dco),
    .dco_cc_valid_o (dv),
    .locked_o       (lk),
    .gear_state_o   (gs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) begin : monitor
    exp_t x;
    #1;
    if (dv) begin
      strobes++;
      if (sbq.size() == 0) begin
        check("spurious_strobe", 1, 0);
      end else begin
        x = sbq.pop_front();
        check("strobe_latency", cyc, x.due);
        check("dco_stream", int'(dco), x.val);
      end
    end
  end

  task automatic model_reset();
    m_acc  = 0;
    m_gear = 0;
    m_cnt  = 0;
  endtask

  task automatic model_step(input int e, input int kpv, input int kiv, input bit f,
                            output int d);
    int kpe, kie, p, mag;
    kpe = (m_gear == 0) ? kpv * 4 : kpv;
    kie = (m_gear == 0) ? kiv * 4 : kiv;
    if (!f) begin
      m_acc = m_acc + e * kie;
      if (m_acc > 15360) m_acc = 15360;
      if (m_acc < -16384) m_acc = -16384;
    end
    p = (e * kpe) >>> 4;
    d = 16 + p + (m_acc >>> 10);
    if (d < 0) d = 0;
    if (d > 31) d = 31;
    if (!f) begin
      mag = (e < 0) ? -e : e;
      if (mag <= 2) begin
        m_cnt = (m_cnt < 16) ? m_cnt + 1 : 16;
        if (m_gear == 0 && m_cnt == 16) begin
          m_gear = 1;
          m_cnt  = 0;
        end else if (m_gear == 1 && m_cnt == 16) begin
          m_gear = 2;
          m_cnt  = 0;
        end
      end else begin
        m_cnt = 0;
        if (m_gear == 1 && mag > 8) m_gear = 0;
        else if (m_gear == 2) m_gear = 1;
      end
    end
  endtask

  task automatic send(input int e, input int kpv, input int kiv, input bit f);
    int d;
    @(negedge clk);
    err = 8'(e);
    kp  = 5'(kpv);
    ki  = 11'(kiv);
    frz = f;
    ev  = 1'b1;
    model_step(e, kpv, kiv, f, d);
    sbq.push_back('{cyc + 2, d});
  endtask

  task automatic drain();
    @(negedge clk);
    ev = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Valid held high during reset: reset must still win
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ev  = 1'b1;
    err = 8'sd10;
    sbq.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ev  = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int s0;
    //             rst   e     kp ki frz   reps exp_dco gear
    tbl.push_back('{1'b1, 10,   1, 1, 1'b0, 1,   18, 0});
    tbl.push_back('{1'b0, 10,   1, 1, 1'b0, 24,  18, 0});
    tbl.push_back('{1'b0, 10,   1, 1, 1'b0, 1,   19, 0});
    tbl.push_back('{1'b0, 10,   1, 1, 1'b0, 374, 31, 0});
    tbl.push_back('{1'b0, -10,  1, 1, 1'b0, 1,   27, 0});
    tbl.push_back('{1'b1, -100, 1, 0, 1'b0, 1,   0,  0});
    tbl.push_back('{1'b0, 1,    1, 1, 1'b0, 16,  16, 1});
    tbl.push_back('{1'b0, 1,    1, 1, 1'b0, 16,  16, 2});
    tbl.push_back('{1'b0, 3,    1, 1, 1'b0, 1,   16, 1});
    tbl.push_back('{1'b0, 9,    1, 1, 1'b0, 1,   16, 0});
    tbl.push_back('{1'b0, 1,    1, 1, 1'b0, 16,  16, 1});
    tbl.push_back('{1'b0, 1,    1, 1, 1'b0, 10,  16, 1});
    tbl.push_back('{1'b0, 8,    1, 1, 1'b0, 1,   16, 1});
    tbl.push_back('{1'b0, 1,    1, 1, 1'b0, 15,  16, 1});
    tbl.push_back('{1'b0, 1,    1, 1, 1'b0, 1,   16, 2});
    tbl.push_back('{1'b1, 10,   1, 1, 1'b1, 100, 18, 0});
    tbl.push_back('{1'b0, 1,    1, 1, 1'b1, 20,  16, 0});

    for (int r = 0; r < tbl.size(); r++) begin
      if (tbl[r].rst) begin
        do_reset();
        #1;
        check($sformatf("reset_dco_row%0d", r), int'(dco), 16);
        check($sformatf("reset_valid_row%0d", r), int'(dv), 0);
        check($sformatf("reset_gear_row%0d", r), int'(gs), 0);
        check($sformatf("reset_locked_row%0d", r), int'(lk), 0);
      end
      for (int n = 0; n < tbl[r].reps; n++)
        send(tbl[r].e, tbl[r].kp, tbl[r].ki, tbl[r].frz);
      drain();
      check($sformatf("row%0d_dco", r), int'(dco), tbl[r].exp_dco);
      check($sformatf("row%0d_gear", r), int'(gs), tbl[r].exp_gear);
      check($sformatf("row%0d_locked", r), int'(lk), (tbl[r].exp_gear == 2) ? 1 : 0);
    end

    // Mid-stream reset: build up integrator and gear, then abort an in-flight sample
    do_reset();
    for (int n = 0; n < 30; n++) send(10, 1, 1, 1'b0);
    drain();
    check("pre_reset_dco", int'(dco), 19);
    for (int n = 0; n < 16; n++) send(1, 1, 1, 1'b0);
    drain();
    check("pre_reset_gear", int'(gs), 1);
    @(negedge clk);
    err = 8'sd10;
    ev  = 1'b1;
    @(negedge clk);
    ev  = 1'b0;
    rst = 1'b1;
    s0  = strobes;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("midreset_no_strobe", strobes - s0, 0);
    check("midreset_dco", int'(dco), 16);
    check("midreset_gear", int'(gs), 0);
    check("midreset_locked", int'(lk), 0);
    send(10, 1, 1, 1'b0);
    drain();
    check("post_reset_dco", int'(dco), 18);

    check("scoreboard_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
